// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU control unit and ram_256_b.
// Validates size/alignment, sequences RAM enable/mode/op_code and sign-extends loads.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned READ_WAIT     = 2,
  parameter int unsigned WRITE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mfa,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        cpu_moc,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy,
  output logic        ram_enable,
  output logic        ram_w_r,
  output logic [1:0]  ram_op_code,
  output logic [7:0]  ram_address,
  output logic [31:0] ram_data_out,
  input  logic        ram_moc,
  input  logic [31:0] ram_data_in
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_TIMEOUT - 1);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_rw;
  logic [1:0]       req_size;
  logic             req_signed;
  logic             illegal_c;
  logic [31:0]      load_ext_c;

  // Request legality: size must be defined and the address naturally aligned.
  always_comb begin
    illegal_c = 1'b0;
    case (size)
      SZ_BYTE: illegal_c = 1'b0;
      SZ_HALF: illegal_c = addr[0];
      SZ_WORD: illegal_c = (addr[1:0] != 2'b00);
      default: illegal_c = 1'b1;
    endcase
  end

  // The RAM zero-pads narrow reads, so only signed byte/halfword loads need work.
  always_comb begin
    load_ext_c = ram_data_in;
    if (req_signed) begin
      case (req_size)
        SZ_BYTE: load_ext_c = {{24{ram_data_in[7]}}, ram_data_in[7:0]};
        SZ_HALF: load_ext_c = {{16{ram_data_in[15]}}, ram_data_in[15:0]};
        default: load_ext_c = ram_data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_rw       <= 1'b1;
      req_size     <= SZ_BYTE;
      req_signed   <= 1'b0;
      cpu_moc      <= 1'b0;
      fault        <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      ram_enable   <= 1'b0;
      ram_w_r      <= 1'b1;
      ram_op_code  <= '0;
      ram_address  <= '0;
      ram_data_out <= '0;
    end else begin
      cpu_moc <= 1'b0;
      fault   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mfa) begin
            req_rw     <= rw;
            req_size   <= size;
            req_signed <= signed_ld;
            busy       <= 1'b1;
            cnt        <= '0;
            if (illegal_c) begin
              state   <= S_FAULT;
              cpu_moc <= 1'b1;
              fault   <= 1'b1;
            end else begin
              // Mode and op_code settle here, a full cycle before enable rises.
              state        <= S_SETUP;
              ram_w_r      <= rw;
              ram_op_code  <= size;
              ram_address  <= addr;
              ram_data_out <= wdata;
            end
          end
        end
        S_SETUP: begin
          state      <= S_ACCESS;
          ram_enable <= 1'b1;
          cnt        <= '0;
        end
        S_ACCESS: begin
          if (req_rw) begin
            if (cnt == READ_LAST) begin
              rdata      <= load_ext_c;
              ram_enable <= 1'b0;
              cpu_moc    <= 1'b1;
              state      <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (ram_moc) begin
            ram_enable <= 1'b0;
            cpu_moc    <= 1'b1;
            state      <= S_DONE;
          end else if (cnt == WRITE_LAST) begin
            ram_enable <= 1'b0;
            cpu_moc    <= 1'b1;
            fault      <= 1'b1;
            state      <= S_FAULT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE, S_FAULT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          ram_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: big-endian byte RAM model with configurable MOC delay,
// and a byte-array reference memory used to predict every load result.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int RD_LAT = 3;   // cpu_moc seen after E3 for READ_WAIT=2
  localparam int TO_LAT = 16;  // 15 ACCESS cycles after SETUP

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mfa = 1'b0, rw = 1'b1, signed_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        cpu_moc, fault, busy, ram_enable, ram_w_r;
  logic [31:0] rdata, ram_data_out, ram_data_in;
  logic [1:0]  ram_op_code;
  logic [7:0]  ram_address;
  logic        ram_moc = 1'b0;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        moc_block = 1'b0;
  logic        sync_req = 1'b0;
  int          wdelay = 0;
  int          wcnt = 0;
  logic [31:0] last_rdata = 32'h0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset_n(reset_n), .mfa(mfa), .rw(rw), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .cpu_moc(cpu_moc),
    .rdata(rdata), .fault(fault), .busy(busy), .ram_enable(ram_enable),
    .ram_w_r(ram_w_r), .ram_op_code(ram_op_code), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_moc(ram_moc), .ram_data_in(ram_data_in)
  );

  // RAM model: zero-padded big-endian reads, writes acknowledged after wdelay edges.
  always_comb begin
    case (ram_op_code)
      2'b00:   ram_data_in = {24'h0, mem[ram_address]};
      2'b01:   ram_data_in = {16'h0, mem[ram_address], mem[8'(ram_address + 8'd1)]};
      default: ram_data_in = {mem[ram_address], mem[8'(ram_address + 8'd1)],
                              mem[8'(ram_address + 8'd2)], mem[8'(ram_address + 8'd3)]};
    endcase
  end

  always @(posedge clk) begin
    if (sync_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (!ram_enable || ram_w_r) begin
      ram_moc <= 1'b0;
      wcnt    <= 0;
    end else if (!moc_block && !ram_moc) begin
      if (wcnt == wdelay) begin
        ram_moc <= 1'b1;
        case (ram_op_code)
          2'b00: mem[ram_address] <= ram_data_out[7:0];
          2'b01: begin
            mem[ram_address]              <= ram_data_out[15:8];
            mem[8'(ram_address + 8'd1)]   <= ram_data_out[7:0];
          end
          default: begin
            mem[ram_address]              <= ram_data_out[31:24];
            mem[8'(ram_address + 8'd1)]   <= ram_data_out[23:16];
            mem[8'(ram_address + 8'd2)]   <= ram_data_out[15:8];
            mem[8'(ram_address + 8'd3)]   <= ram_data_out[7:0];
          end
        endcase
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_legal(input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'b11) return 1'b0;
    return (int'(a) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [7:0] a);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[8'(int'(a) + i)]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) ref_mem[8'(int'(a) + i)] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic sync_mem();
    @(negedge clk); sync_req = 1'b1;
    @(negedge clk); sync_req = 1'b0;
  endtask

  // One CPU handshake; reports latency (edges after E0), fault, rdata and enable cycles.
  task automatic run_access(input logic r, input logic [1:0] sz, input logic sg,
                            input logic [7:0] a, input logic [31:0] wd,
                            output int lat, output logic flt, output logic [31:0] rd,
                            output int en);
    bit done = 1'b0;
    lat = -1; flt = 1'b0; rd = 32'h0; en = 0;
    @(negedge clk);
    mfa = 1'b1; rw = r; size = sz; signed_ld = sg; addr = a; wdata = wd;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      if (ram_enable) en++;
      if (cpu_moc) begin
        lat = n; flt = fault; rd = rdata; mfa = 1'b0; done = 1'b1;
      end
    end
    mfa = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_moc, fault, busy, ram_enable, ram_w_r} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00001", {cpu_moc, fault, busy, ram_enable, ram_w_r});
    end
    checks++;
    if ({ram_op_code, ram_address, ram_data_out, rdata} !== 74'h0) begin
      errors++; $display("FAIL reset_data: op=%h a=%h d=%h r=%h want all 0", ram_op_code, ram_address, ram_data_out, rdata);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    sync_mem();
  endtask

  task automatic test_read_path();
    int lat, en; logic flt; logic [31:0] rd;
    ref_mem[0] = 8'hDE; ref_mem[1] = 8'hAD; ref_mem[2] = 8'hBE; ref_mem[3] = 8'hEF;
    sync_mem();
    run_access(1'b1, 2'b10, 1'b0, 8'h00, 32'h0, lat, flt, rd, en);
    checks++;
    if (lat !== RD_LAT || flt !== 1'b0) begin
      errors++; $display("FAIL read_lat: got lat=%0d fault=%b want lat=%0d fault=0", lat, flt, RD_LAT);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_word: got %h want DEADBEEF", rd);
    end
    checks++;
    if (en !== 2) begin
      errors++; $display("FAIL read_enable: got %0d cycles want 2", en);
    end
    last_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_write_readback();
    int lat, en; logic flt; logic [31:0] rd;
    wdelay = 1;
    run_access(1'b0, 2'b00, 1'b0, 8'h00, 32'h123456CC, lat, flt, rd, en);
    model_store(2'b00, 8'h00, 32'h123456CC);
    checks++;
    if (lat !== 3 + wdelay || flt !== 1'b0) begin
      errors++; $display("FAIL store_byte: got lat=%0d fault=%b want lat=%0d fault=0", lat, flt, 3 + wdelay);
    end
    run_access(1'b1, 2'b00, 1'b0, 8'h00, 32'h0, lat, flt, rd, en);
    checks++;
    if (rd !== 32'h000000CC) begin
      errors++; $display("FAIL load_ubyte: got %h want 000000CC", rd);
    end
    run_access(1'b1, 2'b00, 1'b1, 8'h00, 32'h0, lat, flt, rd, en);
    checks++;
    if (rd !== 32'hFFFFFFCC) begin
      errors++; $display("FAIL load_sbyte: got %h want FFFFFFCC", rd);
    end
    last_rdata = 32'hFFFFFFCC;
  endtask

  task automatic test_halfword();
    int lat, en; logic flt; logic [31:0] rd;
    wdelay = 0;
    run_access(1'b0, 2'b01, 1'b0, 8'h02, 32'h0000CACA, lat, flt, rd, en);
    model_store(2'b01, 8'h02, 32'h0000CACA);
    checks++;
    if (flt !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL store_half: got lat=%0d fault=%b want lat=3 fault=0", lat, flt);
    end
    run_access(1'b1, 2'b01, 1'b1, 8'h02, 32'h0, lat, flt, rd, en);
    checks++;
    if (rd !== 32'hFFFFCACA) begin
      errors++; $display("FAIL load_shalf: got %h want FFFFCACA", rd);
    end
    run_access(1'b1, 2'b01, 1'b0, 8'h02, 32'h0, lat, flt, rd, en);
    checks++;
    if (rd !== 32'h0000CACA) begin
      errors++; $display("FAIL load_uhalf: got %h want 0000CACA", rd);
    end
    checks++;
    if (mem[2] !== 8'hCA || mem[3] !== 8'hCA) begin
      errors++; $display("FAIL half_bytes: got %h %h want CA CA", mem[2], mem[3]);
    end
    last_rdata = 32'h0000CACA;
  endtask

  task automatic test_faults();
    int lat, en; logic flt; logic [31:0] rd;
    logic [1:0] szs [3] = '{2'b10, 2'b01, 2'b11};
    logic [7:0] as  [3] = '{8'h06, 8'h03, 8'h00};
    for (int k = 0; k < 3; k++) begin
      run_access(k[0], szs[k], 1'b0, as[k], 32'hA5A5A5A5, lat, flt, rd, en);
      checks++;
      if (lat !== 0 || flt !== 1'b1 || en !== 0 || rd !== last_rdata) begin
        errors++;
        $display("FAIL illegal_%0d: got lat=%0d fault=%b en=%0d rdata=%h want lat=0 fault=1 en=0 rdata=%h",
                 k, lat, flt, en, rd, last_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, en; logic flt; logic [31:0] rd;
    moc_block = 1'b1;
    run_access(1'b0, 2'b10, 1'b0, 8'h10, 32'h01020304, lat, flt, rd, en);
    moc_block = 1'b0;
    checks++;
    if (lat !== TO_LAT || flt !== 1'b1 || en !== 15) begin
      errors++; $display("FAIL write_timeout: got lat=%0d fault=%b en=%0d want lat=%0d fault=1 en=15",
                         lat, flt, en, TO_LAT);
    end
    checks++;
    if (busy !== 1'b0 || ram_enable !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got busy=%b en=%b want 0 0", busy, ram_enable);
    end
    // The RAM never acknowledged, so its contents are left untouched.
    for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = mem[8'h10 + i];
  endtask

  task automatic test_reset_mid_access();
    bit seen = 1'b0;
    moc_block = 1'b1;
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = 2'b10; addr = 8'h20; wdata = 32'h55AA55AA;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (ram_enable) seen = 1'b1;
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (!seen || {cpu_moc, fault, busy, ram_enable, ram_w_r} !== 5'b00001 ||
        {ram_op_code, ram_address, ram_data_out, rdata} !== 74'h0) begin
      errors++; $display("FAIL reset_mid: seen=%b ctrl=%b op=%h a=%h d=%h r=%h want ctrl=00001 rest 0",
                         seen, {cpu_moc, fault, busy, ram_enable, ram_w_r}, ram_op_code, ram_address,
                         ram_data_out, rdata);
    end
    mfa = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_moc !== 1'b0) begin
      errors++; $display("FAIL reset_no_moc: got %b want 0", cpu_moc);
    end
    @(negedge clk) reset_n = 1'b1;
    moc_block = 1'b0;
    last_rdata = 32'h0;
  endtask

  task automatic test_back_to_back();
    int n1 = -1, n2 = -1;
    logic [31:0] r1 = 32'h0, r2 = 32'h0;
    logic b_idle = 1'b1;
    logic [31:0] exp1 = model_load(2'b10, 1'b0, 8'h00);
    logic [31:0] exp2 = model_load(2'b10, 1'b0, 8'h04);
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; size = 2'b10; signed_ld = 1'b0; addr = 8'h00;
    for (int n = 0; n < 30 && n2 < 0; n++) begin
      @(posedge clk); #1;
      if (n1 >= 0 && n == n1 + 1) b_idle = busy;
      if (cpu_moc) begin
        if (n1 < 0) begin
          n1 = n; r1 = rdata; addr = 8'h04;
        end else begin
          n2 = n; r2 = rdata; mfa = 1'b0;
        end
      end
    end
    mfa = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n1 !== RD_LAT || r1 !== exp1) begin
      errors++; $display("FAIL b2b_first: got lat=%0d rdata=%h want lat=%0d rdata=%h", n1, r1, RD_LAT, exp1);
    end
    checks++;
    if (b_idle !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b want 0 between accesses", b_idle);
    end
    checks++;
    if (n2 !== n1 + 2 + RD_LAT || r2 !== exp2) begin
      errors++; $display("FAIL b2b_second: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                         n2, r2, n1 + 2 + RD_LAT, exp2);
    end
    last_rdata = exp2;
  endtask

  task automatic test_random();
    int lat, en, exp_lat;
    logic flt; logic [31:0] rd, exp_rd;
    logic r, sg; logic [1:0] sz; logic [7:0] a; logic [31:0] wd;
    for (int k = 0; k < 60; k++) begin
      r  = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = 8'((int'(a) / nbytes(sz)) * nbytes(sz));
      wd = $urandom;
      wdelay = $urandom_range(0, 4);
      exp_rd = last_rdata;
      if (!is_legal(sz, a)) exp_lat = 0;
      else if (r) begin exp_lat = RD_LAT; exp_rd = model_load(sz, sg, a); end
      else exp_lat = 3 + wdelay;
      run_access(r, sz, sg, a, wd, lat, flt, rd, en);
      if (is_legal(sz, a) && !r) model_store(sz, a, wd);
      checks++;
      if (lat !== exp_lat || flt !== !is_legal(sz, a) || rd !== exp_rd ||
          en !== (is_legal(sz, a) ? exp_lat - 1 : 0)) begin
        errors++;
        $display("FAIL rand_%0d rw=%b sz=%b a=%h sg=%b: got lat=%0d f=%b rd=%h en=%0d want lat=%0d f=%b rd=%h",
                 k, r, sz, a, sg, lat, flt, rd, en, exp_lat, !is_legal(sz, a), exp_rd);
      end
      last_rdata = exp_rd;
    end
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL ram_contents: got %0d differing bytes want 0", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_path();
    test_write_readback();
    test_halfword();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Clocked memory-access sequencer that sits directly upstream of ram_256_b, between the CPU control unit and the RAM.
- Accepts one load/store request at a time using the CPU-side MFA/MOC handshake.
- Checks size and alignment, then drives the RAM's enable, w_r_mode, op_code, address and data lines with correct setup.
- Completes writes on the RAM's MOC, with a timeout; completes reads after a fixed latency. Sign-extends signed loads.

Parameters:
READ_WAIT, 2, cycles enable is held high on a read before ram_data_in is captured (1..15)
WRITE_TIMEOUT, 15, cycles in ACCESS without ram_moc before a write faults (1..255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mfa  in  1  CPU memory-function-active request, level
rw  in  1  1 = read (load), 0 = write (store); same polarity as RAM w_r_mode
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
signed_ld  in  1  sign-extend load result (byte/halfword only)
addr  in  8  byte address
wdata  in  32  store data, right-aligned
cpu_moc  out  1  one-cycle completion pulse to CPU
rdata  out  32  load result, valid while cpu_moc=1, held afterwards
fault  out  1  one-cycle pulse coincident with cpu_moc on an aborted access
busy  out  1  high in every state except IDLE
ram_enable  out  1  to RAM enable
ram_w_r  out  1  to RAM w_r_mode
ram_op_code  out  2  to RAM op_code
ram_address  out  8  to RAM address
ram_data_out  out  32  to RAM data_input
ram_moc  in  1  from RAM MOC
ram_data_in  in  32  from RAM mem

Behaviour:
Reset (asynchronous, any state):
- State goes to IDLE.
- cpu_moc, fault, busy, ram_enable, ram_op_code, ram_address, ram_data_out, rdata all go to 0; ram_w_r goes to 1.
- Counters clear.
- Reset in mid-access drops ram_enable immediately and returns no cpu_moc.

States: IDLE, SETUP, ACCESS, DONE, FAULT.

IDLE:
- On a clock edge with mfa=1, latch rw, size, signed_ld, addr and wdata.
- Illegal request goes to FAULT. Illegal means size=11, halfword with addr[0]=1, or word with addr[1:0]!=00.
- Legal request goes to SETUP.
- mfa=0 stays in IDLE.

SETUP (1 cycle):
- ram_enable=0; drive ram_w_r, ram_op_code, ram_address and ram_data_out from the latched values.
- ram_w_r and ram_op_code change only while ram_enable=0, because the RAM is sensitive to w_r_mode edges.
- Next state is ACCESS.

ACCESS:
- ram_enable=1 so the RAM sees a rising edge; address, data and op_code are held stable.
- Read: count READ_WAIT cycles. On the edge ending the last one, capture rdata, then go to DONE.
  - Byte, signed_ld=1: rdata = {24{ram_data_in[7]}, ram_data_in[7:0]}.
  - Halfword, signed_ld=1: sign-extend bit 15.
  - Otherwise: rdata = ram_data_in unchanged (the RAM zero-pads).
  - signed_ld is ignored for word.
- Write: go to DONE on the first edge sampling ram_moc=1. If WRITE_TIMEOUT cycles pass without it, go to FAULT.

DONE (1 cycle):
- cpu_moc=1, ram_enable=0.
- Next state is IDLE; mfa is ignored in this cycle.
- CPU must drop mfa on seeing cpu_moc. mfa still high in the following IDLE cycle is a new request.

FAULT (1 cycle):
- cpu_moc=1, fault=1, ram_enable=0. rdata is unchanged and the RAM is never enabled for illegal requests.
- Next state is IDLE.

Latency (sampling edge = E0):
- Read: cpu_moc high in the cycle after edge E(READ_WAIT+1), i.e. after E3 for the default.
- Write: cpu_moc high in the cycle after the edge that samples ram_moc=1.
- Illegal request: fault and cpu_moc high in the cycle after E0.

Other rules:
- Requests arriving while busy=1 are ignored, not queued.
- Address arithmetic is done by the RAM. Aligned accesses never span past 255.

Test Plan:
- Read path: preload RAM bytes 0..3 = DE AD BE EF; word read at addr 0 -> cpu_moc after E3, rdata=DEADBEEF, ram_enable high exactly 2 cycles.
- Write then read back: store byte CC at addr 0 -> cpu_moc after ram_moc; then byte load -> 000000CC; signed byte load -> FFFFFFCC.
- Halfword path: store CACA at addr 2, then load with signed_ld=1 -> FFFFCACA; with signed_ld=0 -> 0000CACA; RAM bytes 2,3 = CA,CA.
- Faults: word at addr 6, halfword at addr 3, size=11 -> fault=cpu_moc=1 one cycle after E0; ram_enable never rises; rdata unchanged.
- Write timeout: tie ram_moc=0, store word -> fault after 15 ACCESS cycles; ram_enable drops; busy clears next cycle.
- Reset and back-to-back: reset_n low mid-ACCESS -> all outputs at reset values asynchronously, no cpu_moc. Two back-to-back reads with mfa held one extra cycle -> second access starts from IDLE, never from DONE.
